adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 70 +++++++
 tb/tb_adder_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one external registered 4-bit adder between two requesters
// ports: clk, rst (async, active-high)
//        req0/req1: valid, a, b in; ready out (operand handshake, accepted in IDLE only)
//        rsp0/rsp1: valid out, ready in; rsp_s/rsp_c shared result
//        add_a/add_b out, add_s/add_c in: link to the shared registered adder
//        busy: high whenever the FSM is not IDLE
module adder_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [3:0] rsp_s,
  output logic       rsp_c,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_s,
  input  logic       add_c,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state, next;
  logic last_grant, grant, pick, accept, done;
  always_comb begin
    pick = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    accept = state == IDLE && (req0_valid || req1_valid);
    done = state == RESP && (grant ? rsp1_ready : rsp0_ready);
    next = state == IDLE ? (accept ? ISSUE : IDLE) :
           state == ISSUE ? CAPTURE :
           state == CAPTURE ? RESP :
           done ? IDLE : RESP;
    // ready is combinational, so it is masked while reset holds the FSM in IDLE
    req0_ready = accept && !pick && !rst;
    req1_ready = accept && pick && !rst;
    rsp0_valid = state == RESP && !grant;
    rsp1_valid = state == RESP && grant;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      add_a <= '0;
      add_b <= '0;
      rsp_s <= '0;
      rsp_c <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        grant <= pick;
        last_grant <= pick;
        add_a <= pick ? req1_a : req0_a;
        add_b <= pick ? req1_b : req0_b;
      end
      if (state == CAPTURE) begin
        rsp_s <= add_s;
        rsp_c <= add_c;
      end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter with a registered adder model attached
module tb_adder_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic rsp0_valid, rsp1_valid, rsp0_ready = 1, rsp1_ready = 1;
  logic [3:0] rsp_s, add_a, add_b, add_s;
  logic rsp_c, add_c, busy;
  always #5 clk = ~clk;
  adder_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_s(rsp_s), .rsp_c(rsp_c),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_c(add_c),
    .busy(busy)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) {add_c, add_s} <= '0;
    else {add_c, add_s} <= {1'b0, add_a} + {1'b0, add_b};
  typedef struct packed {logic p; logic [3:0] s; logic c; logic [31:0] cy;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic push(input logic p, input logic [3:0] s, input logic c);
    exp_t e;
    e.p = p; e.s = s; e.c = c; e.cy = cyc;
    q.push_back(e);
  endtask
  logic in_resp = 0;
  exp_t cur = '0;
  always @(negedge clk) begin
    if (rst) in_resp = 0;
    else begin
      chk("one_rsp_valid", {31'd0, rsp0_valid & rsp1_valid}, 0);
      if (busy) chk("no_ready_when_busy", {30'd0, req1_ready, req0_ready}, 0);
      if ((rsp0_valid || rsp1_valid) && !in_resp) begin
        in_resp = 1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=rsp0:%0d rsp1:%0d required=none", rsp0_valid, rsp1_valid);
          cur = '0;
        end else begin
          cur = q.pop_front();
          chk("rsp_port", {31'd0, rsp1_valid}, {31'd0, cur.p});
          chk("rsp_s", {28'd0, rsp_s}, {28'd0, cur.s});
          chk("rsp_c", {31'd0, rsp_c}, {31'd0, cur.c});
          chk("rsp_latency", cyc - cur.cy, 3);
        end
      end else if (in_resp && (rsp0_valid || rsp1_valid)) begin
        chk("hold_port", {31'd0, rsp1_valid}, {31'd0, cur.p});
        chk("hold_s", {28'd0, rsp_s}, {28'd0, cur.s});
        chk("hold_c", {31'd0, rsp_c}, {31'd0, cur.c});
      end
      if (!(rsp0_valid || rsp1_valid)) in_resp = 0;
    end
  end
  task automatic wait_accept(input logic p, input logic [3:0] s, input logic c);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout actual=no_ready required=ready%0d", p);
    end else begin
      chk("grant_port", {31'd0, req1_ready}, {31'd0, p});
      push(p, s, c);
    end
  endtask
  task automatic issue(input logic p, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] s, input logic c);
    @(posedge clk); #1;
    if (p) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else begin req0_valid = 1; req0_a = a; req0_b = b; end
    wait_accept(p, s, c);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask
  task automatic wait_idle();
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL idle_timeout actual=busy:%0d pending:%0d required=idle", busy, q.size());
    end
  endtask
  task automatic wait_rsp0();
    bit got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp0_valid) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rsp0_timeout actual=0 required=1");
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    req0_valid = 1; req0_a = 3; req0_b = 4;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {13'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_s, rsp_c,
                          add_a, add_b, busy}, 0);
    rst = 0; #1;
    chk("first_edge_ready0", {31'd0, req0_ready}, 1);
    chk("first_edge_ready1", {31'd0, req1_ready}, 0);
    push(0, 4'd7, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    chk("add_a_loaded", {28'd0, add_a}, 3);
    chk("add_b_loaded", {28'd0, add_b}, 4);
    wait_idle();
    chk("add_a_held", {28'd0, add_a}, 3);
    chk("add_b_held", {28'd0, add_b}, 4);
    issue(1, 4'd9, 4'd8, 4'd1, 1);
    wait_idle();
    issue(1, 4'd15, 4'd15, 4'd14, 1);
    wait_idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_a = 2; req1_b = 2;
    wait_accept(0, 4'd2, 0);
    wait_accept(1, 4'd4, 0);
    wait_accept(0, 4'd2, 0);
    wait_accept(1, 4'd4, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    @(posedge clk); #1;
    rsp0_ready = 0; req0_valid = 1; req0_a = 5; req0_b = 6;
    wait_accept(0, 4'd11, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 1; req1_a = 1; req1_b = 2;
    wait_rsp0();
    repeat (5) begin
      chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 1);
      chk("bp_busy", {31'd0, busy}, 1);
      chk("bp_rsp_s", {28'd0, rsp_s}, 11);
      chk("bp_req1_ready", {31'd0, req1_ready}, 0);
      @(negedge clk);
    end
    rsp0_ready = 1;
    wait_accept(1, 4'd3, 0);
    @(posedge clk); #1;
    req1_valid = 0;
    wait_idle();
    @(posedge clk); #1;
    rsp0_ready = 0; rsp1_ready = 1; req0_valid = 1; req0_a = 7; req0_b = 8;
    wait_accept(0, 4'd15, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    wait_rsp0();
    repeat (2) begin
      @(negedge clk);
      chk("wrong_port_rsp0_valid", {31'd0, rsp0_valid}, 1);
      chk("wrong_port_busy", {31'd0, busy}, 1);
    end
    rsp0_ready = 1;
    wait_idle();
    @(posedge clk); #1;
    req1_valid = 1; req1_a = 2; req1_b = 3;
    wait_accept(1, 4'd5, 0);
    if (q.size() > 0) void'(q.pop_back());
    @(posedge clk); #1;
    req1_valid = 0;
    repeat (2) @(negedge clk);
    chk("capture_busy", {31'd0, busy}, 1);
    rst = 1;
    req0_valid = 1; req0_a = 4; req0_b = 4;
    #1;
    chk("midop_reset_outputs", {13'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_s, rsp_c,
                                add_a, add_b, busy}, 0);
    repeat (2) @(negedge clk);
    req0_valid = 0;
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
      chk("post_reset_idle", {31'd0, busy}, 0);
    end
    issue(0, 4'd4, 4'd4, 4'd8, 0);
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
